// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_pkg: shared state encoding, cause-bit positions and width helper for the reset sequencer.
package rst_seq_pkg;
  typedef enum logic [1:0] {ASSERT = 2'b00, RELEASE = 2'b01, DONE = 2'b10} state_t;
  localparam int SRC_EXT = 0;
  localparam int SRC_SW = 1;
  function automatic int cw(input int v);
    return $clog2(v) + 1;
  endfunction
endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: reset request inputs and sequenced reset outputs of one clock domain.
interface rst_seq_ctrl_if #(parameter int NUM_CH = 3);
  logic rst_req_n;
  logic sw_rst;
  logic [NUM_CH-1:0] sync_rst;
  logic rst_done;
  logic [1:0] last_src;
  modport master(output rst_req_n, sw_rst, input sync_rst, rst_done, last_src);
  modport slave(input rst_req_n, sw_rst, output sync_rst, rst_done, last_src);
endinterface

// File: rtl/rst_seq_ctrl_bit_sync.sv
// bit_sync: STAGES-deep single-bit synchroniser with synchronous active-low clear.
module bit_sync #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk) chain <= !rst_n ? '0 : {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: asserts all channel resets together on any request, then releases them in index order.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 3,
  parameter int MIN_ASSERT  = 4,
  parameter int RELEASE_GAP = 2
) (
  input logic clk,
  input logic rst,
  rst_seq_ctrl_if.slave bus
);
  localparam int CW = cw(MIN_ASSERT > RELEASE_GAP ? MIN_ASSERT : RELEASE_GAP);
  localparam int IW = cw(NUM_CH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [NUM_CH-1:0] sync_rst;
  logic rst_done;
  logic [1:0] last_src;
  logic req_q;
  logic ext_req;
  logic req;
  bit_sync #(.STAGES(NUM_STAGES)) u_sync (.clk(clk), .rst_n(rst), .d(bus.rst_req_n), .q(req_q));
  assign ext_req = ~req_q;
  assign req = ext_req | bus.sw_rst;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= ASSERT;
      cnt <= '0;
      idx <= '0;
      sync_rst <= '0;
      rst_done <= 1'b0;
      last_src <= 2'b01;
    end else if (req) begin
      state <= ASSERT;
      cnt <= '0;
      idx <= '0;
      sync_rst <= '0;
      rst_done <= 1'b0;
      last_src[SRC_SW] <= bus.sw_rst;
      last_src[SRC_EXT] <= ext_req;
    end else
      case (state)
        ASSERT:
          if (cnt == CW'(MIN_ASSERT - 1)) begin
            sync_rst <= NUM_CH'(1);
            cnt <= '0;
            if (NUM_CH == 1) begin
              state <= DONE;
              rst_done <= 1'b1;
            end else begin
              state <= RELEASE;
              idx <= IW'(1);
            end
          end else cnt <= cnt + CW'(1);
        RELEASE:
          if (cnt == CW'(RELEASE_GAP - 1)) begin
            sync_rst <= sync_rst | (NUM_CH'(1) << idx);
            cnt <= '0;
            idx <= idx + IW'(1);
            if (idx == IW'(NUM_CH - 1)) begin
              state <= DONE;
              rst_done <= 1'b1;
            end
          end else cnt <= cnt + CW'(1);
        default: ;
      endcase
  assign bus.sync_rst = sync_rst;
  assign bus.rst_done = rst_done;
  assign bus.last_src = last_src;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: two sequencers (3-channel default, 1-channel minimal) checked against an analytic release timeline.
module tb_rst_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int edge_cnt = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    int t;
    logic [2:0] s0;
    logic d0;
    logic s1;
    logic d1;
    logic [1:0] src;
  } exp_t;
  exp_t q[$];
  rst_seq_ctrl_if #(.NUM_CH(3)) b0();
  rst_seq_ctrl_if #(.NUM_CH(1)) b1();
  rst_seq_ctrl #(.NUM_STAGES(2), .NUM_CH(3), .MIN_ASSERT(4), .RELEASE_GAP(2))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rst_seq_ctrl #(.NUM_STAGES(2), .NUM_CH(1), .MIN_ASSERT(1), .RELEASE_GAP(1))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  // channels released after edge t, given the last edge that saw a request
  function automatic int released(input int t, input int last, input int nc, input int ma, input int gap);
    int k;
    if (t < last + ma) return 0;
    k = 1 + (t - last - ma) / gap;
    return k > nc ? nc : k;
  endfunction
  task automatic push_span(input int from, input int to, input int last, input logic [1:0] src);
    for (int t = from; t <= to; t++) begin
      exp_t e;
      int k0;
      int k1;
      k0 = released(t, last, 3, 4, 2);
      k1 = released(t, last, 1, 1, 1);
      e.t = t;
      e.s0 = 3'((1 << k0) - 1);
      e.d0 = (k0 == 3);
      e.s1 = (k1 == 1);
      e.d1 = (k1 == 1);
      e.src = src;
      q.push_back(e);
    end
  endtask
  task automatic wait_to(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask
  task automatic drive(input logic req_n, input logic sw);
    b0.rst_req_n = req_n;
    b1.rst_req_n = req_n;
    b0.sw_rst = sw;
    b1.sw_rst = sw;
  endtask
  always @(negedge clk)
    while (q.size() != 0 && q[0].t == edge_cnt) begin
      exp_t e;
      e = q.pop_front();
      total += 5;
      assert (b0.sync_rst === e.s0) else begin bad++; $error("FAIL sync_rst3 edge=%0d got=%b exp=%b", e.t, b0.sync_rst, e.s0); end
      assert (b0.rst_done === e.d0) else begin bad++; $error("FAIL rst_done3 edge=%0d got=%b exp=%b", e.t, b0.rst_done, e.d0); end
      assert (b0.last_src === e.src) else begin bad++; $error("FAIL last_src3 edge=%0d got=%b exp=%b", e.t, b0.last_src, e.src); end
      assert (b1.sync_rst === e.s1) else begin bad++; $error("FAIL sync_rst1 edge=%0d got=%b exp=%b", e.t, b1.sync_rst, e.s1); end
      assert (b1.rst_done === e.d1) else begin bad++; $error("FAIL rst_done1 edge=%0d got=%b exp=%b", e.t, b1.rst_done, e.d1); end
    end
  initial begin
    drive(1'b1, 1'b0);
    push_span(1, 10, 4, 2'b01);
    wait_to(2);
    rst = 1'b1;
    wait_to(10);
    push_span(11, 24, 11, 2'b10);
    drive(1'b1, 1'b1);
    wait_to(11);
    drive(1'b1, 1'b0);
    wait_to(24);
    push_span(25, 26, 11, 2'b10);
    push_span(27, 46, 36, 2'b01);
    drive(1'b0, 1'b0);
    wait_to(34);
    drive(1'b1, 1'b0);
    wait_to(46);
    push_span(47, 48, 36, 2'b01);
    push_span(49, 53, 49, 2'b11);
    drive(1'b0, 1'b0);
    wait_to(47);
    drive(1'b1, 1'b0);
    wait_to(48);
    drive(1'b1, 1'b1);
    wait_to(49);
    drive(1'b1, 1'b0);
    wait_to(53);
    push_span(54, 66, 56, 2'b01);
    rst = 1'b0;
    wait_to(54);
    rst = 1'b1;
    wait_to(68);
    total++;
    assert (q.size() == 0) else begin bad++; $error("FAIL pending got=%0d exp=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised reset release sequencer, the successor to the single-output 2-flop reset synchroniser. It synchronises an external asynchronous reset request and accepts a software reset pulse. It drives NUM_CH active-low reset outputs that all assert together and release one by one, in index order, with a programmable gap. It sits at the top of each clock domain and feeds reset to that domain's blocks in dependency order: register file, then ALU/UART, then the system controller.

Parameters:
NUM_STAGES, 2, synchroniser depth for RST_REQ_N; legal range 2..4
NUM_CH, 3, number of sequenced reset outputs; legal range 1..16
MIN_ASSERT, 4, minimum cycles all outputs stay low after the last active request; must be >= 1
RELEASE_GAP, 2, cycles between successive channel releases; must be >= 1

Ports:
CLK  input  1  domain clock
RST  input  1  reset, synchronous, active-low; sampled only on posedge CLK
RST_REQ_N  input  1  external reset request, asynchronous, active-low
SW_RST  input  1  software reset request, synchronous to CLK, active-high
SYNC_RST  output  NUM_CH  registered active-low channel resets; bit 0 releases first
RST_DONE  output  1  registered; high once all channels are released
LAST_SRC  output  2  registered cause of the last sequence: bit0 = external/power-on, bit1 = software

Behaviour:
- Reset (RST=0 at posedge): sync chain=0, state=ASSERT, cnt=0, idx=0, SYNC_RST=0, RST_DONE=0, LAST_SRC=2'b01.
- Sync chain: NUM_STAGES flops shifting in RST_REQ_N; ext_req = ~chain[NUM_STAGES-1].
- req = ext_req | SW_RST. req has priority over all FSM activity.
- On any edge with req=1:
  - next SYNC_RST=0, RST_DONE=0, state=ASSERT, cnt=0, idx=0.
  - LAST_SRC <= {SW_RST, ext_req}.
  - This applies in every state, including mid-release.
- ASSERT (req=0):
  - if cnt==MIN_ASSERT-1: SYNC_RST[0]<=1, cnt<=0.
    - NUM_CH==1: go to DONE with RST_DONE<=1.
    - otherwise: go to RELEASE with idx<=1.
  - else cnt<=cnt+1.
- RELEASE (req=0):
  - if cnt==RELEASE_GAP-1: SYNC_RST[idx]<=1, cnt<=0, idx<=idx+1.
    - if idx==NUM_CH-1: go to DONE, RST_DONE<=1.
  - else cnt<=cnt+1.
- DONE: hold all outputs until req or RST.
- Guarantees:
  - Outputs are low for at least MIN_ASSERT cycles after the last req cycle.
  - Consecutive releases are exactly RELEASE_GAP cycles apart.
  - Released channels are always a contiguous low-index prefix (thermometer code).
  - No output glitches.
- Widths:
  - cnt width = clog2(max(MIN_ASSERT,RELEASE_GAP))+1.
  - idx width = clog2(NUM_CH)+1.
  - No wrap is possible because cnt is cleared at terminal count.
- Simultaneous ext_req and SW_RST: both LAST_SRC bits are set.
- RST_REQ_N pulses shorter than one CLK period may be missed; this is not a requirement to catch them.
- RST low overrides req.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum ASSERT/RELEASE/DONE (2-bit encoding 00/01/10)
  - LAST_SRC bit positions
  - clog2-based width function for cnt/idx
- One sub-module: bit_sync (NUM_STAGES-deep single-bit synchroniser with sync active-low clear). It is reused by other CDC blocks.

Test Plan:
- Power-on, defaults, RST_REQ_N=1, RST deasserted before edge 1 -> SYNC_RST=000 through edge 5; 001 after edge 6; 011 after edge 8; 111 and RST_DONE=1 after edge 10; LAST_SRC=01.
- SW_RST one-cycle pulse sampled at edge 9 (SYNC_RST=011) -> SYNC_RST=000 and RST_DONE=0 after edge 9; 001 after edge 13; 011 after edge 15; 111 after edge 17; LAST_SRC=10.
- RST_REQ_N held low 10 cycles while in DONE -> all outputs low 2 cycles after the falling sample, held low while the request is held plus 2 sync cycles plus MIN_ASSERT=4, then the normal release sequence; LAST_SRC=01.
- RST_REQ_N low and SW_RST in the same effective cycle -> LAST_SRC=11; the sequence restarts once.
- NUM_CH=1, MIN_ASSERT=1, RELEASE_GAP=1 -> SYNC_RST[0] and RST_DONE rise on the same edge, 1 cycle after req clears.
- RST=0 asserted mid-RELEASE (SYNC_RST=001) -> next edge all outputs at reset values; sequence restarts after RST=1.
